// File: rtl/sample_capture_if.sv
// Bundles the sample input, trigger control and readout handshake of sample_capture.
// The master modport is the side that drives samples and consumes readout.
// The slave modport is the capture block itself.
interface sample_capture_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         arm;
  logic [W-2:0] thresh;
  logic         busy;
  logic         done;
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic [W-2:0] peak;

  modport master (
    output in_valid, in_data, arm, thresh, rd_ready,
    input  busy, done, rd_valid, rd_data, rd_last, peak
  );

  modport slave (
    input  in_valid, in_data, arm, thresh, rd_ready,
    output busy, done, rd_valid, rd_data, rd_last, peak
  );
endinterface

// File: rtl/sample_capture.sv
// sample_capture: triggered capture of 2^AW signed samples into a buffer,
// followed by an in-order readout over a valid/ready handshake.
// Trigger: first valid sample in ARMED whose saturated magnitude >= thresh.
// Optional feature macro: CAPTURE_PEAK_EN. When defined, peak tracks the
// largest captured magnitude. When undefined, peak is tied to zero.
module sample_capture #(
  parameter int W  = 16,
  parameter int AW = 6
) (
  input  logic             clk,
  input  logic             rst,
  sample_capture_if.slave  bus
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [W-1:0]  r_rd_data;

  logic [W-2:0]  w_mag;
  logic          w_trig;
  logic          w_cap_wr;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic          w_xfer;

  // Absolute value of a two's-complement sample.
  // The most negative code has no positive counterpart and saturates to all ones.
  function automatic logic [W-2:0] f_mag(input logic [W-1:0] x);
    logic [W-1:0] v_neg;
    v_neg = ~x + {{(W-1){1'b0}}, 1'b1};
    if (!x[W-1]) begin
      f_mag = x[W-2:0];
    end else if (x[W-2:0] == {(W-1){1'b0}}) begin
      f_mag = {(W-1){1'b1}};
    end else begin
      f_mag = v_neg[W-2:0];
    end
  endfunction

  // Trigger, capture-write and readout-transfer qualifiers.
  always_comb begin
    w_mag     = f_mag(bus.in_data);
    w_trig    = (r_state == S_ARMED) && bus.in_valid && (w_mag >= bus.thresh);
    w_cap_wr  = (r_state == S_CAPTURE) && bus.in_valid;
    w_wr_en   = w_trig || w_cap_wr;
    w_xfer    = r_rd_valid && bus.rd_ready;
    if (w_trig) begin
      w_wr_addr = {AW{1'b0}};
    end else begin
      w_wr_addr = r_wr_cnt;
    end
  end

  // Next-state decode; arm and in_valid are simply not looked at where they must be ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.arm) w_state_nxt = S_ARMED;
        else         w_state_nxt = S_IDLE;
      end
      S_ARMED: begin
        if (w_trig) w_state_nxt = S_CAPTURE;
        else        w_state_nxt = S_ARMED;
      end
      S_CAPTURE: begin
        if (w_cap_wr && (r_wr_cnt == {AW{1'b1}})) w_state_nxt = S_READOUT;
        else                                      w_state_nxt = S_CAPTURE;
      end
      S_READOUT: begin
        if (w_xfer && r_rd_last) w_state_nxt = S_IDLE;
        else                     w_state_nxt = S_READOUT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample buffer; contents deliberately survive reset and are only seen after being rewritten.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= bus.in_data;
    end
  end

  // Write counter, status flags and the registered readout pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt   <= {AW{1'b0}};
      r_rd_addr  <= {AW{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= {W{1'b0}};
    end else begin
      r_busy <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_CAPTURE);
      r_done <= (w_state_nxt == S_READOUT);

      if (w_trig) begin
        r_wr_cnt <= {{(AW-1){1'b0}}, 1'b1};
      end else if (w_cap_wr) begin
        r_wr_cnt <= r_wr_cnt + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        r_wr_cnt <= r_wr_cnt;
      end

      // The read pointer always runs one ahead of the sample being presented.
      if (w_trig) begin
        r_rd_addr <= {AW{1'b0}};
      end else if ((r_state == S_READOUT) && (!r_rd_valid || (w_xfer && !r_rd_last))) begin
        r_rd_data  <= r_mem[r_rd_addr];
        r_rd_last  <= (r_rd_addr == {AW{1'b1}});
        r_rd_valid <= 1'b1;
        r_rd_addr  <= r_rd_addr + {{(AW-1){1'b0}}, 1'b1};
      end else if (w_xfer && r_rd_last) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end else begin
        r_rd_addr <= r_rd_addr;
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_last  = r_rd_last;
  assign bus.rd_data  = r_rd_data;

`ifdef CAPTURE_PEAK_EN
  logic [W-2:0] r_peak;

  // Peak magnitude: load at trigger, running max during capture, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak <= {(W-1){1'b0}};
    end else if (w_trig) begin
      r_peak <= w_mag;
    end else if (w_cap_wr && (w_mag > r_peak)) begin
      r_peak <= w_mag;
    end else begin
      r_peak <= r_peak;
    end
  end

  assign bus.peak = r_peak;
`else
  assign bus.peak = {(W-1){1'b0}};
`endif

endmodule
